// File: rtl/bullet_engine.sv
// bullet_engine: fixed-size table of moving bullets for a video game arena.
// A frame_tick starts a sweep that visits one slot per cycle. Each active slot
// moves by its velocity, retires at the arena edge (or wraps), and is tested
// against the player position for a collision.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   frame_tick    one-cycle pulse per frame, starts a sweep
//   spawn_valid   spawn request; accepted when spawn_ready is also high
//   spawn_ready   IDLE, table not full, and no frame_tick this cycle
//   spawn_pos     {x, y} of new bullet
//   spawn_vel     {vx, vy}, 4-bit two's complement each
//   spawn_color   colour code of new bullet
//   player_pos    {x, y} of player for collision tests
//   rd_index      renderer slot select
//   rd_pos        registered position of selected slot
//   rd_color      registered colour of selected slot
//   rd_active     registered occupancy of selected slot
//   hit           one-cycle pulse per collision
//   hit_count     saturating collision count
//   active_count  number of occupied slots
//   overrun       sticky; frame_tick seen during a sweep
module bullet_engine #(
  parameter int NUM_BULLETS = 8,
  parameter int HIT_R       = 4,
  parameter int WRAP        = 0,
  localparam int IDX_W      = $clog2(NUM_BULLETS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             spawn_valid,
  output logic             spawn_ready,
  input  logic [15:0]      spawn_pos,
  input  logic [7:0]       spawn_vel,
  input  logic [2:0]       spawn_color,
  input  logic [15:0]      player_pos,
  input  logic [IDX_W-1:0] rd_index,
  output logic [15:0]      rd_pos,
  output logic [2:0]       rd_color,
  output logic             rd_active,
  output logic             hit,
  output logic [7:0]       hit_count,
  output logic [IDX_W:0]   active_count,
  output logic             overrun
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       sweep_idx;

  logic [NUM_BULLETS-1:0] active;
  logic [15:0]            pos   [NUM_BULLETS];
  logic [7:0]             vel   [NUM_BULLETS];
  logic [2:0]             color [NUM_BULLETS];

  logic [NUM_BULLETS-1:0] nxt_active;
  logic [15:0]            nxt_pos   [NUM_BULLETS];
  logic [7:0]             nxt_vel   [NUM_BULLETS];
  logic [2:0]             nxt_color [NUM_BULLETS];

  logic                   spawn_fire;
  logic [IDX_W-1:0]       free_idx;
  logic [15:0]            cur_pos;
  logic [7:0]             cur_vel;
  logic [8:0]             x9;
  logic [8:0]             y9;
  logic [7:0]             nx;
  logic [7:0]             ny;
  logic [7:0]             dx;
  logic [7:0]             dy;
  logic                   do_move;
  logic                   retire_edge;
  logic                   collide;

  assign spawn_ready = (state == IDLE) &&
                       (active_count < (IDX_W+1)'(NUM_BULLETS)) &&
                       !frame_tick;
  assign spawn_fire  = spawn_valid && spawn_ready;

  // Lowest-index free slot: scan downward so the last hit is the lowest.
  always_comb begin
    free_idx = '0;
    for (int unsigned i = NUM_BULLETS; i > 0; i--) begin
      if (!active[i-1]) free_idx = IDX_W'(i-1);
    end
  end

  // Movement and collision for the slot currently being swept.
  always_comb begin
    cur_pos = pos[sweep_idx];
    cur_vel = vel[sweep_idx];
    // Bit 8 of the 9-bit sum is set both for results below 0 and above 255,
    // so it alone flags an off-arena coordinate.
    x9 = {1'b0, cur_pos[15:8]} + {{5{cur_vel[7]}}, cur_vel[7:4]};
    y9 = {1'b0, cur_pos[7:0]}  + {{5{cur_vel[3]}}, cur_vel[3:0]};
    nx = x9[7:0];
    ny = y9[7:0];
    dx = (nx >= player_pos[15:8]) ? nx - player_pos[15:8] : player_pos[15:8] - nx;
    dy = (ny >= player_pos[7:0])  ? ny - player_pos[7:0]  : player_pos[7:0]  - ny;
    do_move     = (state == SWEEP) && active[sweep_idx];
    retire_edge = do_move && (WRAP == 0) && (x9[8] || y9[8]);
    collide     = do_move && !retire_edge &&
                  (int'(dx) < HIT_R) && (int'(dy) < HIT_R);
  end

  // Next-state slot table; rd_* sample this so reads see the same edge's update.
  always_comb begin
    nxt_active = active;
    nxt_pos    = pos;
    nxt_vel    = vel;
    nxt_color  = color;
    if (do_move) begin
      if (retire_edge) begin
        nxt_active[sweep_idx] = 1'b0;
      end else begin
        nxt_pos[sweep_idx] = {nx, ny};
        if (collide) nxt_active[sweep_idx] = 1'b0;
      end
    end
    if (spawn_fire) begin
      nxt_active[free_idx] = 1'b1;
      nxt_pos[free_idx]    = spawn_pos;
      nxt_vel[free_idx]    = spawn_vel;
      nxt_color[free_idx]  = spawn_color;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      sweep_idx    <= '0;
      active       <= '0;
      for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
        pos[i]   <= '0;
        vel[i]   <= '0;
        color[i] <= '0;
      end
      rd_pos       <= '0;
      rd_color     <= '0;
      rd_active    <= 1'b0;
      hit          <= 1'b0;
      hit_count    <= '0;
      active_count <= '0;
      overrun      <= 1'b0;
    end else begin
      active    <= nxt_active;
      pos       <= nxt_pos;
      vel       <= nxt_vel;
      color     <= nxt_color;
      rd_pos    <= nxt_pos[rd_index];
      rd_color  <= nxt_color[rd_index];
      rd_active <= nxt_active[rd_index];
      hit       <= collide;
      if (collide && hit_count != '1) hit_count <= hit_count + 8'd1;
      // Spawns only happen in IDLE and removals only in SWEEP, never together.
      if (spawn_fire)                  active_count <= active_count + (IDX_W+1)'(1);
      else if (retire_edge || collide) active_count <= active_count - (IDX_W+1)'(1);
      case (state)
        IDLE: begin
          if (frame_tick) begin
            state     <= SWEEP;
            sweep_idx <= '0;
          end
        end
        SWEEP: begin
          if (frame_tick) overrun <= 1'b1;
          if (sweep_idx == IDX_W'(NUM_BULLETS-1)) begin
            state     <= IDLE;
            sweep_idx <= '0;
          end else begin
            sweep_idx <= sweep_idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bullet_engine.sv
// Bench for bullet_engine: three instances share stimulus (default, WRAP=1,
// HIT_R=1) and each is compared cycle by cycle against a per-instance
// arithmetic model of the bullet table.
module tb_bullet_engine;

  localparam int NB = 8;
  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        spawn_valid;
  logic [15:0] spawn_pos;
  logic [7:0]  spawn_vel;
  logic [2:0]  spawn_color;
  logic [15:0] player_pos;
  logic [2:0]  rd_index;

  logic        spawn_ready_o  [NI];
  logic [15:0] rd_pos_o       [NI];
  logic [2:0]  rd_color_o     [NI];
  logic        rd_active_o    [NI];
  logic        hit_o          [NI];
  logic [7:0]  hit_count_o    [NI];
  logic [3:0]  active_count_o [NI];
  logic        overrun_o      [NI];

  always #5 clk = ~clk;

  bullet_engine #(.NUM_BULLETS(NB), .HIT_R(4), .WRAP(0)) u_dut0 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready_o[0]),
    .spawn_pos(spawn_pos), .spawn_vel(spawn_vel), .spawn_color(spawn_color),
    .player_pos(player_pos), .rd_index(rd_index),
    .rd_pos(rd_pos_o[0]), .rd_color(rd_color_o[0]), .rd_active(rd_active_o[0]),
    .hit(hit_o[0]), .hit_count(hit_count_o[0]),
    .active_count(active_count_o[0]), .overrun(overrun_o[0]));

  bullet_engine #(.NUM_BULLETS(NB), .HIT_R(4), .WRAP(1)) u_dut1 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready_o[1]),
    .spawn_pos(spawn_pos), .spawn_vel(spawn_vel), .spawn_color(spawn_color),
    .player_pos(player_pos), .rd_index(rd_index),
    .rd_pos(rd_pos_o[1]), .rd_color(rd_color_o[1]), .rd_active(rd_active_o[1]),
    .hit(hit_o[1]), .hit_count(hit_count_o[1]),
    .active_count(active_count_o[1]), .overrun(overrun_o[1]));

  bullet_engine #(.NUM_BULLETS(NB), .HIT_R(1), .WRAP(0)) u_dut2 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready_o[2]),
    .spawn_pos(spawn_pos), .spawn_vel(spawn_vel), .spawn_color(spawn_color),
    .player_pos(player_pos), .rd_index(rd_index),
    .rd_pos(rd_pos_o[2]), .rd_color(rd_color_o[2]), .rd_active(rd_active_o[2]),
    .hit(hit_o[2]), .hit_count(hit_count_o[2]),
    .active_count(active_count_o[2]), .overrun(overrun_o[2]));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic string tg(input string s, input int k);
    return $sformatf("%s[%0d]", s, k);
  endfunction

  // ---------------- reference model ----------------
  bit m_act  [NI][NB];
  int m_pos  [NI][NB];
  int m_vel  [NI][NB];
  int m_col  [NI][NB];
  bit m_sw   [NI];
  int m_slot [NI];
  int m_hits [NI];
  bit m_ovr  [NI];
  bit m_hit  [NI];

  function automatic int p_wrap(input int k); return (k == 1) ? 1 : 0; endfunction
  function automatic int p_hr(input int k);   return (k == 2) ? 1 : 4; endfunction
  function automatic int sx4(input int v);    return (v >= 8) ? v - 16 : v; endfunction
  function automatic int iabs(input int v);   return (v < 0) ? -v : v; endfunction

  function automatic int m_count(input int k);
    int c = 0;
    for (int i = 0; i < NB; i++) c += int'(m_act[k][i]);
    return c;
  endfunction

  function automatic bit m_ready(input int k);
    return !m_sw[k] && (m_count(k) < NB) && !frame_tick;
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < NB; i++) begin
        m_act[k][i] = 0; m_pos[k][i] = 0; m_vel[k][i] = 0; m_col[k][i] = 0;
      end
      m_sw[k] = 0; m_slot[k] = 0; m_hits[k] = 0; m_ovr[k] = 0; m_hit[k] = 0;
    end
  endfunction

  function automatic void m_edge(input int k);
    bit rdy;
    bit found;
    int x, y, px, py, s;
    rdy = m_ready(k);
    m_hit[k] = 0;
    if (m_sw[k]) begin
      if (frame_tick) m_ovr[k] = 1;
      s = m_slot[k];
      if (m_act[k][s]) begin
        x = m_pos[k][s] / 256 + sx4(m_vel[k][s] / 16);
        y = m_pos[k][s] % 256 + sx4(m_vel[k][s] % 16);
        if (p_wrap(k) == 0 && (x < 0 || x > 255 || y < 0 || y > 255)) begin
          m_act[k][s] = 0;
        end else begin
          x = (x + 256) % 256;
          y = (y + 256) % 256;
          m_pos[k][s] = x * 256 + y;
          px = int'(player_pos[15:8]);
          py = int'(player_pos[7:0]);
          if (iabs(x - px) < p_hr(k) && iabs(y - py) < p_hr(k)) begin
            m_act[k][s] = 0;
            m_hit[k] = 1;
            if (m_hits[k] < 255) m_hits[k]++;
          end
        end
      end
      m_slot[k]++;
      if (m_slot[k] == NB) m_sw[k] = 0;
    end else if (frame_tick) begin
      m_sw[k] = 1;
      m_slot[k] = 0;
    end else if (spawn_valid && rdy) begin
      found = 0;
      for (int i = 0; i < NB; i++) begin
        if (!found && !m_act[k][i]) begin
          found = 1;
          m_act[k][i] = 1;
          m_pos[k][i] = int'(spawn_pos);
          m_vel[k][i] = int'(spawn_vel);
          m_col[k][i] = int'(spawn_color);
        end
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  // Called just after a falling edge with inputs driven; returns at the next falling edge.
  task automatic step();
    #1;
    for (int k = 0; k < NI; k++) check(tg("spawn_ready", k), spawn_ready_o[k], m_ready(k));
    @(posedge clk);
    for (int k = 0; k < NI; k++) m_edge(k);
    #1;
    for (int k = 0; k < NI; k++) begin
      check(tg("rd_active", k),    rd_active_o[k],    m_act[k][rd_index]);
      check(tg("rd_pos", k),       rd_pos_o[k],       m_pos[k][rd_index]);
      check(tg("rd_color", k),     rd_color_o[k],     m_col[k][rd_index]);
      check(tg("hit", k),          hit_o[k],          m_hit[k]);
      check(tg("hit_count", k),    hit_count_o[k],    m_hits[k]);
      check(tg("active_count", k), active_count_o[k], m_count(k));
      check(tg("overrun", k),      overrun_o[k],      m_ovr[k]);
    end
    @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string pfx);
    for (int k = 0; k < NI; k++) begin
      check(tg({pfx, "_rd_pos"}, k),       rd_pos_o[k],       0);
      check(tg({pfx, "_rd_color"}, k),     rd_color_o[k],     0);
      check(tg({pfx, "_rd_active"}, k),    rd_active_o[k],    0);
      check(tg({pfx, "_hit"}, k),          hit_o[k],          0);
      check(tg({pfx, "_hit_count"}, k),    hit_count_o[k],    0);
      check(tg({pfx, "_active_count"}, k), active_count_o[k], 0);
      check(tg({pfx, "_overrun"}, k),      overrun_o[k],      0);
    end
  endtask

  // Asserted mid-cycle, away from any rising edge, to show the reset is asynchronous.
  task automatic do_reset();
    reset = 1'b0;
    frame_tick = 1'b0;
    spawn_valid = 1'b0;
    #1;
    check_zero_outputs("rst");
    m_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic spawn(input logic [15:0] p, input logic [7:0] v, input logic [2:0] c);
    spawn_pos = p; spawn_vel = v; spawn_color = c; spawn_valid = 1'b1;
    step();
    spawn_valid = 1'b0;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (NB) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; frame_tick = 1'b0; spawn_valid = 1'b0;
    spawn_pos = '0; spawn_vel = '0; spawn_color = '0;
    player_pos = 16'h8080; rd_index = '0;
    m_reset();
    #1;
    check_zero_outputs("init");
    @(negedge clk);
    reset = 1'b1;

    // Basic move: 0x1020 + (1,-1) -> 0x111F
    do_reset();
    player_pos = 16'h8080; rd_index = 3'd0;
    spawn(16'h1020, 8'h1F, 3'd5);
    frame();
    check("move_pos", rd_pos_o[0], 16'h111F);
    check("move_color", rd_color_o[0], 3'd5);
    check("move_active", rd_active_o[0], 1'b1);

    // Edge retirement vs wrap
    do_reset();
    spawn(16'hFE10, 8'h30, 3'd2);
    check("edge_count_before", active_count_o[0], 4'd1);
    frame();
    check("edge_count_after", active_count_o[0], 4'd0);
    check("edge_hit_count", hit_count_o[0], 8'd0);
    check("wrap_pos", rd_pos_o[1], 16'h0110);
    check("wrap_active", rd_active_o[1], 1'b1);

    // Collision; HIT_R=1 misses by one unit
    do_reset();
    player_pos = 16'h4040;
    spawn(16'h3E40, 8'h10, 3'd1);
    frame();
    check("hit_count_r4", hit_count_o[0], 8'd1);
    check("hit_inactive_r4", rd_active_o[0], 1'b0);
    check("hit_count_r1", hit_count_o[2], 8'd0);
    check("hit_active_r1", rd_active_o[2], 1'b1);

    // Table fill with spawn_valid held high
    do_reset();
    player_pos = 16'h8080;
    spawn_valid = 1'b1;
    for (int i = 0; i < NB + 2; i++) begin
      rd_index = 3'(i);
      spawn_pos = 16'(16'h0808 + i * 16'h0404);
      spawn_vel = 8'(i);
      spawn_color = 3'(i);
      step();
    end
    #1;
    check("full_ready", spawn_ready_o[0], 1'b0);
    check("full_count", active_count_o[0], 4'd8);
    spawn_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      rd_index = 3'(i);
      step();
    end

    // frame_tick during sweep cycle 3 is ignored and flags overrun
    do_reset();
    player_pos = 16'h8080; rd_index = 3'd0;
    spawn(16'h5050, 8'h11, 3'd3);
    spawn(16'h6060, 8'h22, 3'd4);
    spawn(16'h3030, 8'hFF, 3'd6);
    spawn(16'h2828, 8'h01, 3'd7);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    repeat (3) step();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    repeat (NB - 4 + NB + 2) step();
    check("ovr_flag", overrun_o[0], 1'b1);
    check("ovr_single_move", rd_pos_o[0], 16'h5151);

    // Reset in the middle of a sweep with 4 bullets
    do_reset();
    player_pos = 16'h8080;
    for (int i = 0; i < 4; i++) spawn(16'(16'h2020 + i * 16'h1010), 8'h11, 3'(i));
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    repeat (2) step();
    do_reset();
    #1;
    check("post_reset_ready_comb", spawn_ready_o[0], 1'b1);
    @(negedge clk);
    step();
    check("post_reset_ready", spawn_ready_o[0], 1'b1);
    check("post_reset_count", active_count_o[0], 4'd0);

    // Zero-velocity bullets on the player: many hits, counter saturates
    do_reset();
    player_pos = 16'h2020;
    for (int r = 0; r < 34; r++) begin
      rd_index = 3'(r);
      for (int i = 0; i < NB; i++) spawn(16'h2020, 8'h00, 3'(i));
      frame();
    end
    check("sat_hit_count", hit_count_o[0], 8'd255);

    // Randomised traffic
    do_reset();
    player_pos = 16'h8080;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0)
        player_pos = {8'($urandom_range(16, 240)), 8'($urandom_range(16, 240))};
      frame_tick  = ($urandom_range(0, 24) == 0);
      spawn_valid = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 0)
        spawn_pos = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      else
        spawn_pos = {player_pos[15:8] + 8'($urandom_range(0, 24)) - 8'd12,
                     player_pos[7:0]  + 8'($urandom_range(0, 24)) - 8'd12};
      spawn_vel   = 8'($urandom_range(0, 255));
      spawn_color = 3'($urandom_range(0, 7));
      rd_index    = 3'($urandom_range(0, 7));
      step();
    end
    frame_tick = 1'b0;
    spawn_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bullet_engine.md
BULLET_ENGINE -- requirements
Module: bullet_engine

Interface
REQ-001 SHALL have parameter NUM_BULLETS, default 8, number of bullet slots (2..32).
REQ-002 SHALL have parameter HIT_R, default 4, collision half-width in arena units.
REQ-003 SHALL have parameter WRAP, default 0, where 0 retires a bullet at the arena edge and 1 wraps it modulo 256.
REQ-004 SHALL have derived localparam IDX_W = clog2(NUM_BULLETS).
REQ-005 SHALL have ports:
 clk  in  1  system clock; all state changes on its rising edge
 reset  in  1  asynchronous, active-low reset
 frame_tick  in  1  one-cycle pulse per video frame; starts a movement sweep
 spawn_valid  in  1  spawn request
 spawn_ready  out  1  spawn accepted when high with spawn_valid
 spawn_pos  in  16  {x[15:8], y[7:0]}, arena units
 spawn_vel  in  8  {vx[7:4], vy[3:0]}, two's complement, units per frame
 spawn_color  in  3  bullet colour code
 player_pos  in  16  {x[15:8], y[7:0]}, same format as spawn_pos
 rd_index  in  IDX_W  slot selector for renderer
 rd_pos  out  16  position of selected slot
 rd_color  out  3  colour of selected slot
 rd_active  out  1  selected slot occupied
 hit  out  1  one-cycle pulse per collision
 hit_count  out  8  saturating collision counter
 active_count  out  IDX_W+1  number of occupied slots
 overrun  out  1  sticky; frame_tick arrived during a sweep

Function
REQ-006 SHALL hold per slot: active, pos[15:0], vel[7:0], color[2:0].
REQ-007 SHALL implement FSM IDLE -> SWEEP -> IDLE.
- IDLE -> SWEEP on frame_tick.
- SWEEP visits slot 0..NUM_BULLETS-1, one slot per cycle.
- SWEEP -> IDLE after the last slot, so a sweep takes exactly NUM_BULLETS cycles.
REQ-008 SHALL drive spawn_ready = (state==IDLE) && (active_count < NUM_BULLETS) && !frame_tick.
REQ-009 SHALL, on spawn_valid && spawn_ready, write the lowest-index inactive slot with active=1 and the spawn fields, visible on the read port from the next cycle.
REQ-010 SHALL ignore spawn_valid while spawn_ready is 0; the requester holds its fields until accepted.
REQ-011 SHALL, for an active visited slot, compute x' = x + sext(vx) and y' = y + sext(vy) with a 9-bit signed intermediate.
REQ-012 SHALL, with WRAP=0, clear active when x' or y' falls outside 0..255; otherwise store pos={x'[7:0], y'[7:0]}.
REQ-013 SHALL, with WRAP=1, always store the low 8 bits of x' and y' (modulo 256).
REQ-014 SHALL test collision on the updated position: |x'-px| < HIT_R and |y'-py| < HIT_R, using unsigned 8-bit absolute differences.
REQ-015 SHALL, on collision, clear active, pulse hit for that cycle and increment hit_count, saturating at 255.
REQ-016 SHALL apply edge retirement before the collision test; a retired bullet never hits.
REQ-017 SHALL leave inactive slots untouched during a sweep.
REQ-018 SHALL register rd_pos, rd_color and rd_active from rd_index with one-cycle latency, reflecting slot state after the same edge's update.
REQ-019 SHALL update active_count in the same cycle as each spawn or retirement, so it always equals the popcount of the active bits.
REQ-020 SHALL ignore a frame_tick that arrives in SWEEP and set overrun until reset.
REQ-021 SHALL treat a zero velocity as legal: position unchanged, collision still tested.

Reset
REQ-022 SHALL, while reset=0 and independent of clk, force:
- state=IDLE, all active=0, all slot fields=0;
- rd_pos=0, rd_color=0, rd_active=0;
- hit=0, hit_count=0, active_count=0, overrun=0.
REQ-023 SHALL, on reset asserted mid-sweep, abandon the sweep and restart in IDLE with an empty table after deassertion.

Verification
REQ-024 SHALL cover a spawn at pos=0x1020, vel=0x1F, color=5, followed by frame_tick.
- Required response: after NUM_BULLETS+1 cycles, rd_index=0 gives rd_pos=0x111F, rd_color=5, rd_active=1.
REQ-025 SHALL cover WRAP=0, pos=0xFE10, vel=0x30, then frame_tick.
- Required response: slot retired, active_count decrements 1->0, hit stays 0.
- Same stimulus with WRAP=1 gives pos=0x0110.
REQ-026 SHALL cover player_pos=0x4040 and a bullet at 0x3E40 with vel=0x10, then frame_tick.
- Required response: one hit pulse, hit_count=1, slot inactive.
- With HIT_R=1, no hit occurs.
REQ-027 SHALL cover holding spawn_valid high for NUM_BULLETS+2 requests.
- Required response: exactly NUM_BULLETS accepts into slots 0..N-1 in order, then spawn_ready=0 and active_count=NUM_BULLETS.
REQ-028 SHALL cover a frame_tick issued on sweep cycle 3.
- Required response: the pulse is ignored, overrun=1, and each bullet moves only once.
REQ-029 SHALL cover reset=0 applied mid-sweep with 4 active bullets.
- Required response: all outputs go to 0 immediately, without waiting for clk; spawn_ready=1 on the first edge after release.
